// File: rtl/ov7670_pkg.sv
// OV7670 stream generator shared types: FSM states, pattern selects,
// RGB565 colour-bar table and default 640x480 timing constants.
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBACK,
    ACTIVE,
    VFRONT
  } state_e;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'b00,
    PAT_RAMP  = 2'b01,
    PAT_CHECK = 2'b10,
    PAT_SOLID = 2'b11
  } pat_e;

  // entry 0 is the leftmost bar (white)
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_LINE_TOTAL   = 1568;
  localparam int DEF_VSYNC_LINES  = 3;
  localparam int DEF_VBACK_LINES  = 17;
  localparam int DEF_VFRONT_LINES = 10;

  function automatic logic [15:0] bar_rgb(
    input logic [2:0] idx
  );
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational RGB565 test-pattern source.
// In: x[9:0], y[8:0], sel, solid_rgb. Out: pixel[15:0].
module ov7670_pattern_gen
  import ov7670_pkg::*;
(
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  pat_e        sel,
  input  logic [15:0] solid_rgb,
  output logic [15:0] pixel
);

  logic unused_y;
  assign unused_y = ^y[2:0];

  always_comb begin
    pixel = 16'h0000;
    unique case (sel)
      PAT_BARS:  pixel = bar_rgb(x[9:7]);
      PAT_RAMP:  pixel = {x[9:5], y[8:3], x[4:0]};
      PAT_CHECK: pixel = (x[5] ^ y[5]) ? 16'hFFFF
                                       : 16'h0000;
      PAT_SOLID: pixel = solid_rgb;
      default:   pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera byte stream generator (vsync/href/d, 2 bytes/pixel).
// In: clk25, rst_n, enable, pattern_sel, solid_rgb. Out: vsync, href, d, busy, frame_done, frame_cnt.
module ov7670_stream_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int LINE_TOTAL   = DEF_LINE_TOTAL,
  parameter int VSYNC_LINES  = DEF_VSYNC_LINES,
  parameter int VBACK_LINES  = DEF_VBACK_LINES,
  parameter int VFRONT_LINES = DEF_VFRONT_LINES
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int BW = $clog2(LINE_TOTAL);
  localparam int LW = 10;

  state_e          state, nstate;
  logic [BW-1:0]   byte_cnt, nbyte;
  logic [LW-1:0]   line_cnt, nline;
  logic [LW-1:0]   last_line;
  pat_e            pat_q;
  logic [15:0]     solid_q;

  logic            line_end, state_end;
  logic            start;
  logic            href_n, done_n;
  logic [7:0]      d_n;
  logic [15:0]     pixel;

  always_comb begin
    last_line = '0;
    unique case (state)
      VSYNC:   last_line = LW'(VSYNC_LINES - 1);
      VBACK:   last_line = LW'(VBACK_LINES - 1);
      ACTIVE:  last_line = LW'(V_ACTIVE - 1);
      VFRONT:  last_line = LW'(VFRONT_LINES - 1);
      default: last_line = '0;
    endcase
  end

  assign line_end  = (byte_cnt == BW'(LINE_TOTAL - 1));
  assign state_end = line_end && (line_cnt == last_line);

  // next position; outputs are registered from it so they line up with state
  always_comb begin
    nstate = state;
    nbyte  = byte_cnt;
    nline  = line_cnt;
    if (state == IDLE) begin
      if (enable) nstate = VSYNC;
    end else if (state_end) begin
      nbyte = '0;
      nline = '0;
      unique case (state)
        VSYNC:   nstate = VBACK;
        VBACK:   nstate = ACTIVE;
        ACTIVE:  nstate = VFRONT;
        VFRONT:  nstate = enable ? VSYNC : IDLE;
        default: nstate = IDLE;
      endcase
    end else if (line_end) begin
      nbyte = '0;
      nline = line_cnt + 1'b1;
    end else begin
      nbyte = byte_cnt + 1'b1;
    end
  end

  assign start = (nstate == VSYNC) &&
                 (state == IDLE || state == VFRONT);

  assign done_n = (nstate == VFRONT) &&
                  (nbyte == BW'(LINE_TOTAL - 1)) &&
                  (nline == LW'(VFRONT_LINES - 1));

  assign href_n = (nstate == ACTIVE) &&
                  (nbyte < BW'(2 * H_ACTIVE));

  ov7670_pattern_gen u_pat (
    .x         (10'(nbyte >> 1)),
    .y         (9'(nline)),
    .sel       (pat_q),
    .solid_rgb (solid_q),
    .pixel     (pixel)
  );

  assign d_n = !href_n  ? 8'h00 :
               nbyte[0] ? pixel[7:0] :
                          pixel[15:8];

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      pat_q      <= PAT_BARS;
      solid_q    <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      state      <= nstate;
      byte_cnt   <= nbyte;
      line_cnt   <= nline;
      vsync      <= (nstate == VSYNC);
      href       <= href_n;
      d          <= d_n;
      busy       <= (nstate != IDLE);
      frame_done <= done_n;
      if (done_n) frame_cnt <= frame_cnt + 8'd1;
      if (start) begin
        pat_q   <= pat_e'(pattern_sel);
        solid_q <= solid_rgb;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen: small-timing instance plus a
// default-timing instance for the colour-bar byte check.
module tb_ov7670_stream_gen;

  logic clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  logic        rst_n, enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        vsync, href, busy, frame_done;
  logic [7:0]  d, frame_cnt;

  logic        en_b;
  logic [1:0]  sel_b;
  logic [15:0] solid_b;
  logic        vsync_b, href_b, busy_b, done_b;
  logic [7:0]  d_b, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  ov7670_stream_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .LINE_TOTAL(20),
    .VSYNC_LINES(1), .VBACK_LINES(1), .VFRONT_LINES(1)
  ) dut (
    .clk25(clk25), .rst_n(rst_n), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .vsync(vsync), .href(href), .d(d), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  ov7670_stream_gen dut_big (
    .clk25(clk25), .rst_n(rst_n), .enable(en_b),
    .pattern_sel(sel_b), .solid_rgb(solid_b),
    .vsync(vsync_b), .href(href_b), .d(d_b), .busy(busy_b),
    .frame_done(done_b), .frame_cnt(cnt_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int   p, lp;
  logic act, e_vs, e_hr, e_busy, e_dn, hr_prev;
  logic [7:0] e_d;
  int   vs_hi, hr_pulses, hr_badlen, hr_len, dn_cnt;
  int   err_vs, err_hr, err_d1, err_d2, err_busy, err_dn;
  int   nd, cyc, wait_b;
  int   err_bh, err_b0, err_b1, err_b4;

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    pattern_sel = 2'b11; solid_rgb = 16'hABCD;
    en_b = 1'b0; sel_b = 2'b00; solid_b = 16'h0000;
    repeat (3) @(negedge clk25);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk25);
    chk("idle_vsync", vsync, 0);
    chk("idle_busy", busy, 0);

    // two frames: solid ABCD, then ramp; enable dropped in frame 2
    enable = 1'b1;
    @(negedge clk25);
    vs_hi = 0; hr_pulses = 0; hr_badlen = 0;
    hr_len = 0; dn_cnt = 0; hr_prev = 1'b0;
    err_vs = 0; err_hr = 0; err_d1 = 0; err_d2 = 0;
    err_busy = 0; err_dn = 0;
    for (int i = 0; i < 310; i++) begin
      p = i % 140;
      if (i < 280) begin
        act    = (p >= 40) && (p < 120);
        lp     = act ? (p - 40) % 20 : 0;
        e_vs   = (p < 20);
        e_hr   = act && (lp < 16);
        e_busy = 1'b1;
        e_dn   = (p == 139);
        if (!e_hr)        e_d = 8'h00;
        else if (i < 140) e_d = (lp % 2 == 0) ? 8'hAB : 8'hCD;
        else              e_d = (lp % 2 == 0) ? 8'h00 : 8'(lp / 2);
      end else begin
        e_vs = 1'b0; e_hr = 1'b0; e_busy = 1'b0;
        e_dn = 1'b0; e_d = 8'h00;
      end
      if (vsync !== e_vs) err_vs++;
      if (href !== e_hr) err_hr++;
      if (busy !== e_busy) err_busy++;
      if (frame_done !== e_dn) err_dn++;
      if (d !== e_d) begin
        if (i < 140) err_d1++;
        else         err_d2++;
      end
      vs_hi += int'(vsync);
      dn_cnt += int'(frame_done);
      if (href && !hr_prev) hr_pulses++;
      if (href) hr_len++;
      if (!href && hr_prev) begin
        if (hr_len != 16) hr_badlen++;
        hr_len = 0;
      end
      hr_prev = href;
      if (i == 50) begin
        pattern_sel = 2'b01;
        solid_rgb   = 16'h1234;
      end
      if (i == 200) enable = 1'b0;
      @(negedge clk25);
    end
    chk("vsync_cycles", vs_hi, 40);
    chk("href_pulses", hr_pulses, 8);
    chk("href_badlen", hr_badlen, 0);
    chk("done_pulses", dn_cnt, 2);
    chk("vsync_timing", err_vs, 0);
    chk("href_timing", err_hr, 0);
    chk("busy_timing", err_busy, 0);
    chk("done_timing", err_dn, 0);
    chk("solid_bytes", err_d1, 0);
    chk("ramp_next_frame", err_d2, 0);
    chk("frame_cnt_2", frame_cnt, 2);

    // reset during ACTIVE line 2
    pattern_sel = 2'b11;
    enable = 1'b1;
    @(negedge clk25);
    chk("restart_vsync", vsync, 1);
    repeat (85) @(negedge clk25);
    chk("pre_rst_href", href, 1);
    chk("pre_rst_cnt", frame_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vsync", vsync, 0);
    chk("arst_href", href, 0);
    chk("arst_d", d, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_cnt", frame_cnt, 0);
    repeat (3) @(negedge clk25);
    chk("held_vsync", vsync, 0);
    chk("held_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk25);
    chk("rel_vsync", vsync, 1);
    chk("rel_busy", busy, 1);
    chk("rel_cnt", frame_cnt, 0);

    fork
      begin
        nd = 0;
        for (int i = 0; i < 257 * 140 + 40 && nd < 257; i++) begin
          @(negedge clk25);
          if (frame_done) begin
            nd++;
            if (nd == 255) chk("cnt_255", frame_cnt, 255);
            if (nd == 256) chk("cnt_wrap0", frame_cnt, 0);
          end
        end
        chk("frames_257", nd, 257);
        chk("cnt_after_257", frame_cnt, 1);
        enable = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
          @(negedge clk25);
          cyc++;
        end
        chk("final_idle", busy, 0);
      end
      begin
        en_b = 1'b1;
        @(negedge clk25);
        chk("big_vsync", vsync_b, 1);
        wait_b = 0;
        while (!href_b && wait_b < 40000) begin
          @(negedge clk25);
          wait_b++;
        end
        chk("big_href_start", wait_b, 31360);
        en_b = 1'b0;
        err_bh = 0; err_b0 = 0; err_b1 = 0; err_b4 = 0;
        for (int k = 0; k < 1280; k++) begin
          if (href_b !== 1'b1) err_bh++;
          if (k < 256 && d_b !== 8'hFF) err_b0++;
          if (k >= 256 && k < 512 &&
              d_b !== ((k % 2 == 0) ? 8'hFF : 8'hE0)) err_b1++;
          if (k >= 1024 &&
              d_b !== ((k % 2 == 0) ? 8'hF8 : 8'h1F)) err_b4++;
          @(negedge clk25);
        end
        chk("big_href_len", err_bh, 0);
        chk("big_bar0", err_b0, 0);
        chk("big_bar1", err_b1, 0);
        chk("big_bar4", err_b4, 0);
        chk("big_href_end", href_b, 0);
        chk("big_d_blank", d_b, 0);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
